// File: rtl/sensor_conditioner_pkg.sv
// Shared types and default parameters for the sensor conditioning block.
package sensor_conditioner_pkg;

    localparam int unsigned SAMPLE_DIV_DEF = 50000;
    localparam int unsigned DEB_N_DEF      = 4;
    localparam int unsigned TEMP_N_DEF     = 8;
    localparam int unsigned TEMP_W         = 5;
    localparam int unsigned CNT_W          = 4;

    typedef enum logic {
        WARMUP = 1'b0,
        RUN    = 1'b1
    } cond_state_t;

endpackage

// File: rtl/sensor_conditioner_stable.sv
// Two-flop synchronizer followed by a tick-sampled stability filter.
module stable_filter
    import sensor_conditioner_pkg::*;
#(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned N     = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] value,
    output logic             accepted
);

    logic [WIDTH-1:0] meta;
    logic [WIDTH-1:0] sync;
    logic [WIDTH-1:0] cand;
    logic [WIDTH-1:0] cand_nxt;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_nxt;

    // Bring the asynchronous input into the clk domain.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= '0;
            sync <= '0;
        end else begin
            meta <= raw;
            sync <= meta;
        end
    end

    // Next candidate/count for the coming tick; count saturates at N.
    always_comb begin
        cand_nxt  = cand;
        count_nxt = count;
        if (sync == cand) begin
            if (count != CNT_W'(N)) begin
                count_nxt = count + CNT_W'(1);
            end
        end else begin
            cand_nxt  = sync;
            count_nxt = CNT_W'(1);
        end
    end

    // Advance the filter on ticks only; accept once the count reaches N.
    always_ff @(posedge clk) begin
        if (rst) begin
            cand     <= '0;
            count    <= '0;
            value    <= '0;
            accepted <= 1'b0;
        end else if (tick) begin
            cand  <= cand_nxt;
            count <= count_nxt;
            if (count_nxt == CNT_W'(N)) begin
                value    <= cand_nxt;
                accepted <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/sensor_conditioner.sv
// Debounced temperature/presence/ignition inputs with warm-up gating.
module sensor_conditioner
    import sensor_conditioner_pkg::*;
#(
    parameter int unsigned SAMPLE_DIV = SAMPLE_DIV_DEF,
    parameter int unsigned DEB_N      = DEB_N_DEF,
    parameter int unsigned TEMP_N     = TEMP_N_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [TEMP_W-1:0] temp_raw,
    input  logic              pres_raw,
    input  logic              carro_raw,
    output logic [TEMP_W-1:0] temp_q,
    output logic              pres_q,
    output logic              carro_q,
    output logic              ready,
    output logic              upd
);

    localparam int unsigned DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

    logic [DIV_W-1:0]  div_cnt;
    logic              tick;
    logic [TEMP_W-1:0] f_temp;
    logic              f_pres;
    logic              f_carro;
    logic              acc_temp;
    logic              acc_pres;
    logic              acc_carro;
    cond_state_t       state;

    // Free-running sample divider; tick fires while the counter sits at 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
        end else if (div_cnt == DIV_W'(SAMPLE_DIV - 1)) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    assign tick = (div_cnt == '0);

    stable_filter #(.WIDTH(TEMP_W), .N(TEMP_N)) u_temp (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick),
        .raw      (temp_raw),
        .value    (f_temp),
        .accepted (acc_temp)
    );

    stable_filter #(.WIDTH(1), .N(DEB_N)) u_pres (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick),
        .raw      (pres_raw),
        .value    (f_pres),
        .accepted (acc_pres)
    );

    stable_filter #(.WIDTH(1), .N(DEB_N)) u_carro (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick),
        .raw      (carro_raw),
        .value    (f_carro),
        .accepted (acc_carro)
    );

    // Warm-up gating, output registers and the single-cycle update strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= WARMUP;
            temp_q  <= '0;
            pres_q  <= 1'b0;
            carro_q <= 1'b0;
            ready   <= 1'b0;
            upd     <= 1'b0;
        end else begin
            upd <= 1'b0;
            case (state)
                WARMUP: begin
                    if (acc_temp && acc_pres && acc_carro) begin
                        state   <= RUN;
                        temp_q  <= f_temp;
                        pres_q  <= f_pres;
                        carro_q <= f_carro;
                        ready   <= 1'b1;
                        upd     <= 1'b1;
                    end
                end
                RUN: begin
                    temp_q  <= f_temp;
                    pres_q  <= f_pres;
                    carro_q <= f_carro;
                    if ({f_temp, f_pres, f_carro} != {temp_q, pres_q, carro_q}) begin
                        upd <= 1'b1;
                    end
                end
                default: state <= WARMUP;
            endcase
        end
    end

endmodule

// File: tb/tb_sensor_conditioner.sv
// Scoreboard bench for sensor_conditioner with a sliding-window reference model.
module tb_sensor_conditioner;

    localparam int SDIV = 4;
    localparam int DN   = 2;
    localparam int TN   = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] temp_raw;
    logic       pres_raw;
    logic       carro_raw;
    logic [4:0] temp_q;
    logic       pres_q;
    logic       carro_q;
    logic       ready;
    logic       upd;

    int n_cmp = 0;
    int n_bad = 0;
    int upd_cnt = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    sensor_conditioner #(.SAMPLE_DIV(SDIV), .DEB_N(DN), .TEMP_N(TN)) dut (
        .clk       (clk),
        .rst       (rst),
        .temp_raw  (temp_raw),
        .pres_raw  (pres_raw),
        .carro_raw (carro_raw),
        .temp_q    (temp_q),
        .pres_q    (pres_q),
        .carro_q   (carro_q),
        .ready     (ready),
        .upd       (upd)
    );

    typedef struct packed {
        int         cyc;
        logic [4:0] t;
        logic       p;
        logic       c;
    } exp_t;

    exp_t sb[$];

    // Reference model state: raw history since reset and per-channel tick windows.
    int         edge_cnt = 0;
    int         n_since = 0;
    logic [6:0] hist[$];
    logic [6:0] smp;
    logic [4:0] win_t[$];
    logic       win_p[$];
    logic       win_c[$];
    logic [4:0] f_t;
    logic       f_p, f_c;
    bit         acc_t, acc_p, acc_c;
    logic [4:0] m_t;
    logic       m_p, m_c;
    bit         m_run;
    bit         eq;

    // Model: tick every SDIV clocks after reset, sync = raw two clocks old,
    // a channel is accepted when its last N tick samples all agree.
    always @(posedge clk) begin
        edge_cnt++;
        if (rst) begin
            n_since = 0;
            hist.delete();
            win_t.delete();
            win_p.delete();
            win_c.delete();
            f_t = '0; f_p = 1'b0; f_c = 1'b0;
            acc_t = 1'b0; acc_p = 1'b0; acc_c = 1'b0;
            m_t = '0; m_p = 1'b0; m_c = 1'b0; m_run = 1'b0;
        end else begin
            if (!m_run) begin
                if (acc_t && acc_p && acc_c) begin
                    m_run = 1'b1;
                    m_t = f_t; m_p = f_p; m_c = f_c;
                    sb.push_back('{cyc: edge_cnt, t: f_t, p: f_p, c: f_c});
                end
            end else if ({f_t, f_p, f_c} != {m_t, m_p, m_c}) begin
                m_t = f_t; m_p = f_p; m_c = f_c;
                sb.push_back('{cyc: edge_cnt, t: f_t, p: f_p, c: f_c});
            end
            if (n_since % SDIV == 0) begin
                smp = (n_since >= 2) ? hist[n_since - 2] : 7'd0;
                win_t.push_back(smp[6:2]);
                if (win_t.size() > TN) void'(win_t.pop_front());
                if (win_t.size() == TN) begin
                    eq = 1'b1;
                    foreach (win_t[i]) if (win_t[i] !== win_t[0]) eq = 1'b0;
                    if (eq) begin f_t = win_t[0]; acc_t = 1'b1; end
                end
                win_p.push_back(smp[1]);
                if (win_p.size() > DN) void'(win_p.pop_front());
                if (win_p.size() == DN) begin
                    eq = 1'b1;
                    foreach (win_p[i]) if (win_p[i] !== win_p[0]) eq = 1'b0;
                    if (eq) begin f_p = win_p[0]; acc_p = 1'b1; end
                end
                win_c.push_back(smp[0]);
                if (win_c.size() > DN) void'(win_c.pop_front());
                if (win_c.size() == DN) begin
                    eq = 1'b1;
                    foreach (win_c[i]) if (win_c[i] !== win_c[0]) eq = 1'b0;
                    if (eq) begin f_c = win_c[0]; acc_c = 1'b1; end
                end
            end
            hist.push_back({temp_raw, pres_raw, carro_raw});
            n_since++;
        end
    end

    // Monitor: checks held outputs every cycle and pops the scoreboard on upd.
    exp_t e;
    bit   exp_upd;
    always @(negedge clk) begin
        if (chk_en) begin
            n_cmp++;
            if ({ready, temp_q, pres_q, carro_q} !== {m_run, m_t, m_p, m_c}) begin
                n_bad++;
                $display("FAIL outputs @%0d: got rdy=%b t=%0d p=%b c=%b want rdy=%b t=%0d p=%b c=%b",
                         edge_cnt, ready, temp_q, pres_q, carro_q, m_run, m_t, m_p, m_c);
            end
            exp_upd = (sb.size() > 0) && (sb[0].cyc == edge_cnt);
            n_cmp++;
            if (upd !== exp_upd) begin
                n_bad++;
                $display("FAIL upd @%0d: got %b want %b", edge_cnt, upd, exp_upd);
            end
            if (upd === 1'b1) upd_cnt++;
            if (exp_upd) begin
                e = sb.pop_front();
                n_cmp++;
                if ({temp_q, pres_q, carro_q} !== {e.t, e.p, e.c}) begin
                    n_bad++;
                    $display("FAIL upd_data @%0d: got t=%0d p=%b c=%b want t=%0d p=%b c=%b",
                             edge_cnt, temp_q, pres_q, carro_q, e.t, e.p, e.c);
                end
            end
            while (sb.size() > 0 && sb[0].cyc < edge_cnt) void'(sb.pop_front());
        end
    end

    task automatic check(input string name, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Wait for ready with a bound; ready and upd must rise on the same clock.
    task automatic wait_ready(input string name, input int bound);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < bound && !seen; i++) begin
            @(negedge clk);
            if (ready === 1'b1) seen = 1'b1;
        end
        check({name, "_ready_in_time"}, int'(seen), 1);
        if (seen) check({name, "_upd_with_ready"}, int'(upd), 1);
    endtask

    int u0;
    int gap;
    bit found;
    int hold;

    initial begin
        rst = 1'b1; temp_raw = 5'd20; pres_raw = 1'b1; carro_raw = 1'b0;
        cyc(3);
        chk_en = 1'b1;
        check("reset_ready", int'(ready), 0);
        check("reset_upd", int'(upd), 0);
        check("reset_temp", int'(temp_q), 0);
        rst = 1'b0;

        // Warm-up acceptance
        wait_ready("warmup", 3 * SDIV + 3);
        check("warmup_temp", int'(temp_q), 20);
        check("warmup_pres", int'(pres_q), 1);
        check("warmup_carro", int'(carro_q), 0);
        cyc(2 * SDIV);

        // Short temperature glitch must be rejected
        #1 u0 = upd_cnt;
        @(negedge clk) temp_raw = 5'd25;
        cyc(2 * SDIV);
        temp_raw = 5'd20;
        cyc(6 * SDIV);
        #1;
        check("glitch_temp", int'(temp_q), 20);
        check("glitch_no_upd", upd_cnt - u0, 0);

        // Stable temperature change accepted with one strobe
        @(negedge clk) temp_raw = 5'd31;
        found = 1'b0;
        for (int i = 0; i < (TN + 1) * SDIV + 3 && !found; i++) begin
            @(negedge clk);
            if (upd === 1'b1) found = 1'b1;
        end
        check("temp_upd_seen", int'(found), 1);
        check("temp_31", int'(temp_q), 31);
        cyc(3 * SDIV);
        #1;
        check("temp_one_upd", upd_cnt - u0, 1);

        // Presence and ignition change together
        u0 = upd_cnt;
        @(negedge clk) begin pres_raw = 1'b0; carro_raw = 1'b1; end
        cyc((DN + 3) * SDIV);
        #1;
        check("simul_pres", int'(pres_q), 0);
        check("simul_carro", int'(carro_q), 1);
        check("simul_one_upd", upd_cnt - u0, 1);

        // Reset while a change is qualifying
        @(negedge clk) carro_raw = 1'b0;
        cyc(SDIV + 2);
        rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        check("midrst_ready", int'(ready), 0);
        check("midrst_temp", int'(temp_q), 0);
        check("midrst_carro", int'(carro_q), 0);
        wait_ready("rewarm", 3 * SDIV + 3);
        check("rewarm_temp", int'(temp_q), 31);
        check("rewarm_carro", int'(carro_q), 0);

        // Tick spacing over 10 intervals
        found = 1'b0;
        for (int i = 0; i < 2 * SDIV && !found; i++) begin
            @(negedge clk);
            if (dut.tick === 1'b1) found = 1'b1;
        end
        check("tick_seen", int'(found), 1);
        for (int k = 0; k < 10; k++) begin
            gap = 0;
            found = 1'b0;
            for (int i = 0; i < 4 * SDIV && !found; i++) begin
                @(negedge clk);
                gap++;
                if (dut.tick === 1'b1) found = 1'b1;
            end
            check("tick_gap", gap, SDIV);
        end

        // Randomized traffic, including glitches and occasional resets
        for (int k = 0; k < 250; k++) begin
            @(negedge clk);
            case ($urandom_range(0, 9))
                0, 1, 2, 3: temp_raw = 5'($urandom);
                4, 5:       pres_raw = ~pres_raw;
                6, 7:       carro_raw = ~carro_raw;
                8:          begin temp_raw = 5'($urandom); pres_raw = ~pres_raw; end
                default:    if ($urandom_range(0, 3) == 0) rst = 1'b1;
            endcase
            if (rst) begin
                @(negedge clk) rst = 1'b0;
            end
            hold = $urandom_range(1, 5 * SDIV);
            cyc(hold);
        end
        cyc(12 * SDIV);
        #1;
        check("scoreboard_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
